// File: rtl/dds_pkg.sv
// Shared definitions for the DDS measurement path: frequency-meter FSM
// encoding, clock/step scaling and the double-dabble digit helper.
package dds_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_CONV = 2'd2,
    S_PUB  = 2'd3
  } fm_state_t;

  // System clock and the frequency of one front-panel tuning step.
  localparam int CLK_HZ  = 50_000_000;
  localparam int STEP_HZ = 5000;

  // Gate length such that one counted edge equals one tuning step.
  localparam int GATE_CYCLES_DEF = CLK_HZ / STEP_HZ;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the
  // shift so that it carries correctly into the next decimal digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble), one input bit
// per cycle. The start cycle already performs the first shift, so a CNT_W-bit
// value takes exactly CNT_W cycles and done pulses in the following cycle.
module bin2bcd_seq
  import dds_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_bin,
  output logic [4*BCD_DIGITS-1:0] o_bcd,
  output logic                    o_done
);

  localparam int BCD_W  = 4 * BCD_DIGITS;
  localparam int LEFT_W = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [LEFT_W-1:0] r_left;
  logic              r_done;

  logic [CNT_W-1:0]  w_src_bin;
  logic [BCD_W-1:0]  w_src_bcd;
  logic [BCD_W-1:0]  w_adj;
  logic [CNT_W-1:0]  w_nxt_bin;
  logic [BCD_W-1:0]  w_nxt_bcd;

  // On start the step works on the fresh input with an empty BCD field.
  always_comb begin
    w_src_bin = i_start ? i_bin : r_bin;
    w_src_bcd = i_start ? '0    : r_bcd;
  end

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_dig
    assign w_adj[4*d +: 4] = add3(w_src_bcd[4*d +: 4]);
  end

  // One double-dabble step: correct digits, then shift the binary MSB in.
  always_comb begin
    w_nxt_bcd = {w_adj[BCD_W-2:0], w_src_bin[CNT_W-1]};
    w_nxt_bin = w_src_bin << 1;
  end

  // Shift engine with remaining-shift counter and done strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_left <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_bin  <= w_nxt_bin;
        r_bcd  <= w_nxt_bcd;
        r_left <= LEFT_W'(CNT_W - 1);
        r_done <= (CNT_W == 1);
      end else if (r_left != '0) begin
        r_bin  <= w_nxt_bin;
        r_bcd  <= w_nxt_bcd;
        r_left <= r_left - 1'b1;
        r_done <= (r_left == LEFT_W'(1));
      end
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/freq_meter.sv
// Gated edge-count frequency meter. Counts synchronised rising edges of
// sig_in over GATE_CYCLES clocks, saturates at 2^CNT_W-1, converts the count
// to packed BCD and publishes binary, BCD and overflow with a valid pulse.
// BCD_DIGITS must be large enough that 10^BCD_DIGITS > 2^CNT_W-1.
module freq_meter
  import dds_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = 16,
  parameter int BCD_DIGITS  = 5
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    sig_in,
  input  logic                    meas_en,
  output logic [CNT_W-1:0]        meas_val,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    ovf,
  output logic                    valid,
  output logic                    busy
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int CONV_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int BCD_W  = 4 * BCD_DIGITS;

  // Input conditioning
  logic r_sync1, r_sync2, r_prev;
  logic w_edge;

  // Measurement FSM state
  fm_state_t         r_state;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_ovf_int;
  logic [CONV_W-1:0] r_conv_cnt;
  logic              r_start;

  // Published outputs
  logic [CNT_W-1:0]  r_meas_val;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_ovf;
  logic              r_valid;
  logic              r_busy;

  logic [BCD_W-1:0]  w_conv_bcd;
  logic              w_done;

  // Two-flop synchroniser followed by the previous-value register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  // Gate / convert / publish sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_int  <= 1'b0;
      r_conv_cnt <= '0;
      r_start    <= 1'b0;
      r_meas_val <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (meas_en) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_GATE: begin
          if (!meas_en) begin
            // Abort: drop the partial count, published outputs hold.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (w_edge) begin
              if (r_edge_cnt == '1) r_ovf_int  <= 1'b1;
              else                  r_edge_cnt <= r_edge_cnt + 1'b1;
            end
            if (r_gate_cnt == GATE_W'(GATE_CYCLES - 1)) begin
              // Last gate cycle; the converter samples r_edge_cnt next cycle
              // once this cycle's edge has landed in it.
              r_state    <= S_CONV;
              r_gate_cnt <= '0;
              r_conv_cnt <= '0;
              r_start    <= 1'b1;
            end else begin
              r_gate_cnt <= r_gate_cnt + 1'b1;
            end
          end
        end
        S_CONV: begin
          // meas_en is ignored; the conversion always runs to completion.
          if (r_conv_cnt == CONV_W'(CNT_W - 1)) begin
            r_state <= S_PUB;
            r_busy  <= 1'b0;
          end else begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
          end
        end
        S_PUB: begin
          // The converter's done strobe lands exactly in this cycle.
          if (w_done) begin
            r_meas_val <= r_edge_cnt;
            r_bcd      <= w_conv_bcd;
            r_ovf      <= r_ovf_int;
            r_valid    <= 1'b1;
          end
          if (meas_en) begin
            r_state    <= S_GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  bin2bcd_seq #(
    .CNT_W      (CNT_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .i_clk   (clk),
    .i_rst   (clr),
    .i_start (r_start),
    .i_bin   (r_edge_cnt),
    .o_bcd   (w_conv_bcd),
    .o_done  (w_done)
  );

  assign meas_val = r_meas_val;
  assign bcd      = r_bcd;
  assign ovf      = r_ovf;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter. Two instances share clk/clr/sig_in: A is a
// 16-bit / 5-digit meter, B an 8-bit / 3-digit meter for saturation. Expected
// results come from the recorded sig_in history: rising edges inside the gate
// window (shifted by the synchroniser latency), saturated, then decimal digits.
module tb_freq_meter;

  localparam int G  = 2000;
  localparam int WA = 16;
  localparam int DA = 5;
  localparam int WB = 8;
  localparam int DB = 3;

  typedef struct {
    int         val;
    logic [19:0] bcd;
    bit         ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr, sig_in, meas_en_a, meas_en_b;
  logic [WA-1:0]   mv_a;
  logic [4*DA-1:0] bcd_a;
  logic            ovf_a, vld_a, busy_a;
  logic [WB-1:0]   mv_b;
  logic [4*DB-1:0] bcd_b;
  logic            ovf_b, vld_b, busy_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   hist [0:131071];
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, last_a;
  int   plan [0:7];
  int   gen_mode = 0;
  int   ph = 0;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(WA), .BCD_DIGITS(DA)) u_a (
    .clk(clk), .clr(clr), .sig_in(sig_in), .meas_en(meas_en_a),
    .meas_val(mv_a), .bcd(bcd_a), .ovf(ovf_a), .valid(vld_a), .busy(busy_a));

  freq_meter #(.GATE_CYCLES(G), .CNT_W(WB), .BCD_DIGITS(DB)) u_b (
    .clk(clk), .clr(clr), .sig_in(sig_in), .meas_en(meas_en_b),
    .meas_val(mv_b), .bcd(bcd_b), .ovf(ovf_b), .valid(vld_b), .busy(busy_b));

  always #5 clk = ~clk;

  // Record the sig_in value each clock edge sees; cyc counts edges so far.
  always @(posedge clk) begin
    hist[cyc] = sig_in;
    cyc = cyc + 1;
  end

  // Signal source: -2 random bits, -1 hold high, 0 hold low, else period.
  always @(negedge clk) begin
    if (gen_mode == -2)      sig_in = 1'($urandom);
    else if (gen_mode == -1) sig_in = 1'b1;
    else if (gen_mode == 0)  sig_in = 1'b0;
    else begin
      ph = (ph + 1) % gen_mode;
      sig_in = (ph < gen_mode / 2);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic set_gen(input int mode);
    gen_mode = mode;
    if (mode >= 2) ph = $urandom_range(0, mode - 1);
  endtask

  task automatic set_en(input int inst, input logic v);
    if (inst == 0) meas_en_a = v;
    else           meas_en_b = v;
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? qa.size() : qb.size();
  endfunction

  // Reference result for a gate whose enable is sampled at clock edge k0.
  function automatic exp_t model(input int k0, input int w);
    exp_t e;
    int   n = 0;
    int   maxv = (1 << w) - 1;
    int   v;
    for (int j = k0 - 1; j <= k0 + G - 2; j++)
      if (hist[j] && !hist[j-1]) n++;
    e.ovf = (n > maxv);
    v     = e.ovf ? maxv : n;
    e.val = v;
    e.bcd = '0;
    for (int d = 0; d < 5; d++) begin
      e.bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    e.cyc = k0 + G + w + 2;
    return e;
  endfunction

  // n back-to-back windows on one instance; plan[i] sets window i's source.
  task automatic measure(input int inst, input int n);
    int   k0;
    int   w;
    exp_t e;
    w = (inst == 0) ? WA : WB;
    set_gen(plan[0]);
    repeat (6) @(negedge clk);
    k0 = cyc;
    set_en(inst, 1'b1);
    for (int i = 0; i < n; i++) begin
      while (cyc < k0 + G / 2) @(negedge clk);
      chk(inst == 0 ? "a_busy_gate" : "b_busy_gate", inst == 0 ? busy_a : busy_b, 1);
      while (cyc < k0 + G + 1) @(negedge clk);
      e = model(k0, w);
      if (inst == 0) begin qa.push_back(e); last_a = e; end
      else           qb.push_back(e);
      if (i == n - 1) set_en(inst, 1'b0);
      else begin
        set_gen(plan[i+1]);
        k0 = k0 + G + w + 1;
      end
    end
    for (int t = 0; t < w + 20 && qsize(inst) != 0; t++) @(negedge clk);
    chk("drain", qsize(inst), 0);
    @(negedge clk);
    chk(inst == 0 ? "a_busy_idle" : "b_busy_idle", inst == 0 ? busy_a : busy_b, 0);
  endtask

  // Monitor A: every valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (vld_a) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_valid: valid=1 with no pending result, meas_val=%0d at cycle %0d", mv_a, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_meas_val", mv_a, ea.val);
        chk("a_bcd", bcd_a, ea.bcd);
        chk("a_ovf", ovf_a, ea.ovf);
        chk("a_valid_cycle", cyc, ea.cyc);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (vld_b) begin
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_valid: valid=1 with no pending result, meas_val=%0d at cycle %0d", mv_b, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_meas_val", mv_b, eb.val);
        chk("b_bcd", bcd_b, eb.bcd);
        chk("b_ovf", ovf_b, eb.ovf);
        chk("b_valid_cycle", cyc, eb.cyc);
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k0;
    // Reset with activity on the inputs.
    clr = 1'b1; meas_en_a = 1'b1; meas_en_b = 1'b1;
    set_gen(2);
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid_a", vld_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_valid_b", vld_b, 0);
      chk("rst_busy_b", busy_b, 0);
    end
    chk("rst_meas_val_a", mv_a, 0);
    chk("rst_bcd_a", bcd_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_meas_val_b", mv_b, 0);
    chk("rst_bcd_b", bcd_b, 0);
    clr = 1'b0; meas_en_a = 1'b0; meas_en_b = 1'b0;
    set_gen(0);
    repeat (5) @(negedge clk);

    // Slow square wave: about 5 edges per gate.
    plan[0] = 400;
    measure(0, 1);

    // Fast square wave, three continuous windows (cadence via valid cycle).
    plan[0] = 10; plan[1] = 10; plan[2] = 10;
    measure(0, 3);

    // Held high, then held low: no rising edges inside either gate.
    plan[0] = -1; plan[1] = 0;
    measure(0, 2);

    // Randomised sources.
    plan[0] = $urandom_range(2, 700);
    plan[1] = -2;
    plan[2] = $urandom_range(2, 60);
    measure(0, 3);

    // Known value, then an aborted gate that must not publish.
    plan[0] = 400;
    measure(0, 1);
    set_gen(400);
    k0 = cyc;
    meas_en_a = 1'b1;
    while (cyc < k0 + G / 2) @(negedge clk);
    meas_en_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_meas_val", mv_a, last_a.val);
    chk("abort_bcd", bcd_a, last_a.bcd);
    chk("abort_ovf", ovf_a, last_a.ovf);
    chk("abort_busy", busy_a, 0);

    // Narrow meter: saturating window, then a normal one.
    plan[0] = 4; plan[1] = 400;
    measure(1, 2);

    // Reset in the middle of a conversion.
    set_gen(10);
    repeat (6) @(negedge clk);
    k0 = cyc;
    meas_en_a = 1'b1;
    while (cyc < k0 + G + 5) @(negedge clk);
    chk("pre_clr_busy", busy_a, 1);
    clr = 1'b1; meas_en_a = 1'b0;
    @(negedge clk);
    chk("clr_conv_meas_val", mv_a, 0);
    chk("clr_conv_bcd", bcd_a, 0);
    chk("clr_conv_ovf", ovf_a, 0);
    chk("clr_conv_valid", vld_a, 0);
    chk("clr_conv_busy", busy_a, 0);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_clr_busy", busy_a, 0);
    chk("post_clr_meas_val", mv_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
